i2c_master: RTL and testbench

Byte-level I2C controller that generates the SCL/SDA waveforms consumed by the on-chip `I2C_slave` (and any external I2C target) on the same two-wire bus. A host thread issues one command (7-bit address, direction, byte count); the block produces START, address, data bytes, ACK/NACK handling and STOP. It is the stage directly upstream of the slave and matches the slave's sampling: fixed-rate SCL, no clock-stretching support.

---
 rtl/i2c_master.sv | 241 ++++++++++++++++++++++++
 tb/tb_i2c_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// Byte-level I2C master: START, 7-bit address + R/W, up to 15 data bytes with
// ACK/NACK handling, then STOP. Fixed-rate SCL, no clock stretching.
//
// Write-data handshake: wr_data is captured on the clock edge that raises
// wr_next; the pulse tells the host that byte is consumed, and the host must
// present the following byte before the next wr_next pulse.
module i2c_master #(
    parameter int HALF_PERIOD = 5,
    parameter int SETUP       = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [3:0] len,
    input  logic [7:0] wr_data,
    output logic       wr_next,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       SCL,
    inout  wire        SDA
);
    localparam int CW = $clog2(HALF_PERIOD);
    localparam logic [CW-1:0] CNT_LAST   = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] CNT_SETUP  = CW'(SETUP);
    localparam logic [CW-1:0] CNT_SAMPLE = CW'(HALF_PERIOD / 2);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WRITE,
        S_WRITE_ACK, S_READ, S_READ_ACK, S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    phase_q, phase_d;      // slots: 0 = SCL low, 1 = SCL high; STOP uses 0..2
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    addr_q, addr_d;        // {addr, rw}
    logic [3:0]    rem_q, rem_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          ack_q, ack_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_next_q, wr_next_d;
    logic          done_q, done_d;
    logic          nack_q, nack_d;
    logic          scl_q, scl_d;
    logic          sda_low_q, sda_low_d;

    logic cnt_last, slot_end, sample, drive_low;

    // Next-state logic; bus pins are decoded from the next state so they leave a flop.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        ack_d      = ack_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_next_d  = 1'b0;
        done_d     = 1'b0;
        nack_d     = nack_q;
        scl_d      = 1'b1;
        sda_low_d  = sda_low_q;
        drive_low  = 1'b0;
        cnt_last   = (cnt_q == CNT_LAST);
        slot_end   = cnt_last && phase_q[0];
        sample     = phase_q[0] && (cnt_q == CNT_SAMPLE);

        if (state_q != S_IDLE) begin
            cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // done_q still counts as busy, so a start coincident with done is dropped
                if (start && !done_q) begin
                    state_d = S_START;
                    cnt_d   = '0;
                    phase_d = 2'd0;
                    bit_d   = 3'd0;
                    addr_d  = {addr, rw};
                    rem_d   = len;
                    nack_d  = 1'b0;
                    if (!rw && (len != 4'd0)) begin
                        tx_d      = wr_data;
                        wr_next_d = 1'b1;
                    end
                end
            end
            S_START: begin
                if (cnt_last) begin
                    state_d = S_ADDR;
                    phase_d = 2'd0;
                end
            end
            S_ADDR, S_WRITE, S_READ: begin
                if (cnt_last) phase_d = {1'b0, ~phase_q[0]};
                if (sample && (state_q == S_READ)) begin
                    rx_d = {rx_q[6:0], SDA};
                    if (bit_q == 3'd7) begin
                        rd_data_d  = {rx_q[6:0], SDA};
                        rd_valid_d = 1'b1;
                    end
                end
                if (slot_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        case (state_q)
                            S_ADDR:  state_d = S_ADDR_ACK;
                            S_WRITE: state_d = S_WRITE_ACK;
                            default: state_d = S_READ_ACK;
                        endcase
                    end
                end
            end
            S_ADDR_ACK, S_WRITE_ACK, S_READ_ACK: begin
                if (cnt_last) phase_d = {1'b0, ~phase_q[0]};
                if (sample) ack_d = SDA;
                if (slot_end) begin
                    if ((state_q != S_READ_ACK) && ack_q) begin
                        nack_d  = 1'b1;
                        state_d = S_STOP;
                    end else if (state_q == S_ADDR_ACK) begin
                        if (rem_q == 4'd0) state_d = S_STOP;
                        else               state_d = addr_q[0] ? S_READ : S_WRITE;
                    end else begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == 4'd1) begin
                            state_d = S_STOP;
                        end else begin
                            state_d = state_q == S_WRITE_ACK ? S_WRITE : S_READ;
                            if (state_q == S_WRITE_ACK) begin
                                tx_d      = wr_data;
                                wr_next_d = 1'b1;
                            end
                        end
                    end
                end
            end
            S_STOP: begin
                if (cnt_last) begin
                    if (phase_q == 2'd2) begin
                        state_d = S_IDLE;
                        phase_d = 2'd0;
                        done_d  = 1'b1;
                    end else begin
                        phase_d = phase_q + 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // SDA level the master wants for the next bit slot (1 = pull low)
        case (state_d)
            S_ADDR:     drive_low = ~addr_d[3'd7 - bit_d];
            S_WRITE:    drive_low = ~tx_d[3'd7 - bit_d];
            S_READ_ACK: drive_low = (rem_d != 4'd1);
            default:    drive_low = 1'b0;
        endcase

        case (state_d)
            S_IDLE: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
            S_START: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b1;
            end
            S_STOP: begin
                scl_d = (phase_d != 2'd0);
                if ((phase_d == 2'd0) && (cnt_d == CNT_SETUP)) sda_low_d = 1'b1;
                else if (phase_d == 2'd2)                     sda_low_d = 1'b0;
            end
            default: begin
                scl_d = phase_d[0];
                if (!phase_d[0] && (cnt_d == CNT_SETUP)) sda_low_d = drive_low;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            phase_q    <= 2'd0;
            bit_q      <= 3'd0;
            addr_q     <= 8'h00;
            rem_q      <= 4'd0;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            ack_q      <= 1'b0;
            rd_data_q  <= 8'h00;
            rd_valid_q <= 1'b0;
            wr_next_q  <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            scl_q      <= 1'b1;
            sda_low_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            ack_q      <= ack_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            wr_next_q  <= wr_next_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            scl_q      <= scl_d;
            sda_low_q  <= sda_low_d;
        end
    end

    assign SDA      = sda_low_q ? 1'b0 : 1'bz;
    assign SCL      = scl_q;
    assign wr_next  = wr_next_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign done     = done_q;
    assign nack     = nack_q;
    assign busy     = (state_q != S_IDLE) || done_q;

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: a cycle-sampled I2C target at address 0x49 sits on the
// bus; command records are driven from a table, plus reset and busy corner cases.
`timescale 1ns/1ps
module tb_i2c_master;
    localparam int HP    = 5;
    localparam int LIMIT = 2000;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       rw    = 1'b0;
    logic [6:0] addr  = 7'h00;
    logic [3:0] len   = 4'd0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_next, rd_valid, busy, done, nack, scl;
    logic [7:0] rd_data;
    wire        sda_w;
    logic       tgt_low = 1'b0;

    pullup (sda_w);
    assign sda_w = tgt_low ? 1'b0 : 1'bz;

    always #5 clock = ~clock;

    i2c_master #(.HALF_PERIOD(HP), .SETUP(2)) dut (
        .clock(clock), .reset(reset), .start(start), .addr(addr), .rw(rw),
        .len(len), .wr_data(wr_data), .wr_next(wr_next), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .nack(nack),
        .SCL(scl), .SDA(sda_w)
    );

    // ---------------- bus target model (address 0x49) ----------------
    logic [7:0] got_q[$];     // bytes written to the target
    logic [7:0] addr_log[$];  // every address frame seen on the bus
    logic       mack_q[$];    // master ACK bit after each byte read
    logic       t_scl_p = 1'b1, t_sda_p = 1'b1;
    logic [3:0] t_nbits = 4'd0;
    logic [7:0] t_sh = 8'h00, t_tx = 8'h00;
    logic [1:0] t_mode = 2'd0;  // 0 idle, 1 address, 2 write, 3 read
    logic       t_rw = 1'b0, t_mack = 1'b0;
    int         t_ridx = 0;

    function automatic logic [7:0] tgt_byte(input int i);
        return (i == 0) ? 8'h81 : 8'h7E;
    endfunction

    always @(negedge clock) begin
        t_scl_p <= scl;
        t_sda_p <= sda_w;
        if (!reset) begin
            t_mode  <= 2'd0;
            tgt_low <= 1'b0;
            t_nbits <= 4'd0;
        end else if (scl && t_scl_p && t_sda_p && !sda_w) begin
            t_mode  <= 2'd1;
            t_nbits <= 4'd0;
            t_sh    <= 8'h00;
            tgt_low <= 1'b0;
        end else if (scl && t_scl_p && !t_sda_p && sda_w) begin
            t_mode  <= 2'd0;
            t_nbits <= 4'd0;
            tgt_low <= 1'b0;
        end else if (scl && !t_scl_p) begin
            t_nbits <= t_nbits + 4'd1;
            if (t_nbits < 4'd8) t_sh <= {t_sh[6:0], sda_w};
            if (t_nbits == 4'd7 && t_mode == 2'd1) addr_log.push_back({t_sh[6:0], sda_w});
            if (t_nbits == 4'd7 && t_mode == 2'd2) got_q.push_back({t_sh[6:0], sda_w});
            if (t_nbits == 4'd8 && t_mode == 2'd3) begin
                mack_q.push_back(sda_w);
                t_mack <= sda_w;
            end
        end else if (!scl && t_scl_p) begin
            if (t_nbits == 4'd8) begin
                case (t_mode)
                    2'd1: begin
                        if (t_sh[7:1] == 7'h49) begin
                            tgt_low <= 1'b1;
                            t_rw    <= t_sh[0];
                            t_ridx  <= 0;
                        end else begin
                            t_mode <= 2'd0;
                        end
                    end
                    2'd2:    tgt_low <= 1'b1;
                    default: tgt_low <= 1'b0;
                endcase
            end else if (t_nbits == 4'd9) begin
                t_nbits <= 4'd0;
                case (t_mode)
                    2'd1: begin
                        if (t_rw) begin
                            t_mode  <= 2'd3;
                            t_tx    <= tgt_byte(0);
                            tgt_low <= ~tgt_byte(0)[7];
                        end else begin
                            t_mode  <= 2'd2;
                            tgt_low <= 1'b0;
                        end
                    end
                    2'd3: begin
                        if (!t_mack) begin
                            t_ridx  <= t_ridx + 1;
                            t_tx    <= tgt_byte(t_ridx + 1);
                            tgt_low <= ~tgt_byte(t_ridx + 1)[7];
                        end else begin
                            t_mode  <= 2'd0;
                            tgt_low <= 1'b0;
                        end
                    end
                    default: tgt_low <= 1'b0;
                endcase
            end else if (t_mode == 2'd3 && t_nbits != 4'd0) begin
                tgt_low <= ~t_tx[6];
                t_tx    <= {t_tx[6:0], 1'b0};
            end
        end
    end

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [3:0] len;
        logic [7:0] b0, b1;
        int         exp_cycles;
        logic       exp_nack;
        int         exp_wrn;
        int         exp_ngot;
        int         exp_nrd;
        logic [7:0] r0, r1;
    } vec_t;

    // ---------------- driver ----------------
    // mode 1 additionally pulses start mid-transfer and in the done cycle
    task automatic run_txn(input vec_t v, input int mode);
        int         cycles, wrn, rdv, got0, mack0, alog0, idle_bad;
        logic [7:0] wq[$];
        got0  = got_q.size();
        mack0 = mack_q.size();
        alog0 = addr_log.size();
        wq = '{v.b1, 8'h00};
        exp_q.delete();
        if (v.exp_nrd >= 1) exp_q.push_back(v.r0);
        if (v.exp_nrd >= 2) exp_q.push_back(v.r1);
        @(negedge clock);
        addr = v.addr; rw = v.rw; len = v.len; wr_data = v.b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0; cycles = 1; wrn = 0; rdv = 0;
        check("sda_fall_first_cycle", {scl, sda_w}, 2'b10);
        while (!done && cycles < LIMIT) begin
            if (wr_next) begin
                wrn++;
                wr_data = (wq.size() != 0) ? wq.pop_front() : 8'h00;
            end
            if (rd_valid) begin
                rdv++;
                if (exp_q.size() != 0) check("rd_data", rd_data, exp_q.pop_front());
            end
            if (mode == 1 && cycles == 50) begin
                start = 1'b1; addr = 7'h22; rw = 1'b0; len = 4'd0;
            end else if (mode == 1 && cycles == 51) begin
                start = 1'b0;
            end
            @(negedge clock);
            cycles++;
        end
        check("done_seen", done, 1);
        check("start_to_done", cycles, v.exp_cycles);
        check("busy_in_done", busy, 1);
        if (mode == 1) begin
            start = 1'b1; addr = 7'h22; rw = 1'b0; len = 4'd0;
        end
        @(negedge clock);
        start = 1'b0;
        check("busy_after_done", busy, 0);
        if (mode == 1) begin
            idle_bad = 0;
            repeat (20) begin
                @(negedge clock);
                if (busy || !scl) idle_bad++;
            end
            check("ignored_start_idle", idle_bad, 0);
        end
        check("nack", nack, v.exp_nack);
        check("wr_next_count", wrn, v.exp_wrn);
        check("rd_valid_count", rdv, v.exp_nrd);
        check("addr_frames", addr_log.size() - alog0, 1);
        if (addr_log.size() > alog0) check("addr_byte", addr_log[alog0], {v.addr, v.rw});
        check("target_bytes", got_q.size() - got0, v.exp_ngot);
        for (int i = 0; i < v.exp_ngot; i++) begin
            if (got_q.size() > got0 + i) check("target_data", got_q[got0 + i], (i == 0) ? v.b0 : v.b1);
        end
        check("master_ack_count", mack_q.size() - mack0, v.exp_nrd);
        for (int i = 0; i < v.exp_nrd; i++) begin
            if (mack_q.size() > mack0 + i) check("master_ack_bit", mack_q[mack0 + i], (i == v.exp_nrd - 1) ? 1 : 0);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t vecs[5];
        vecs[0] = '{7'h49, 1'b0, 4'd2, 8'hA5, 8'h3C, 291, 1'b0, 2, 2, 0, 8'h00, 8'h00};
        vecs[1] = '{7'h22, 1'b0, 4'd1, 8'h5A, 8'h00, 111, 1'b1, 1, 0, 0, 8'h00, 8'h00};
        vecs[2] = '{7'h49, 1'b1, 4'd2, 8'h00, 8'h00, 291, 1'b0, 0, 0, 2, 8'h81, 8'h7E};
        vecs[3] = '{7'h49, 1'b0, 4'd0, 8'h00, 8'h00, 111, 1'b0, 0, 0, 0, 8'h00, 8'h00};
        vecs[4] = '{7'h49, 1'b1, 4'd1, 8'h00, 8'h00, 201, 1'b0, 0, 0, 1, 8'h81, 8'h00};

        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_scl", scl, 1);
        check("rst_sda", sda_w, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack, 0);
        check("rst_wr_next", wr_next, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 8'h00);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 5; i++) run_txn(vecs[i], 0);

        // reset during the third address bit, then a clean transfer
        @(negedge clock);
        addr = 7'h49; rw = 1'b0; len = 4'd1; wr_data = 8'h11; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (27) @(negedge clock);
        check("bit2_scl_low", scl, 0);
        check("bit2_busy", busy, 1);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_scl", scl, 1);
        check("midrst_sda", sda_w, 1);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        reset = 1'b1;
        @(negedge clock);
        run_txn(vecs[0], 0);

        // starts while busy and coincident with done are dropped
        run_txn(vecs[3], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
